car_flow_ctrl: RTL and testbench
================================

CAR_FLOW_CTRL -- requirements
Module: car_flow_ctrl

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on each sensor input (legal range 2..3).
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 sens_a  input  1  raw outer photo-sensor, 1 = beam blocked, asynchronous to clk.
REQ-005 sens_b  input  1  raw inner photo-sensor, 1 = beam blocked, asynchronous to clk.
REQ-006 units  input  4  current BCD units digit from the occupancy counter.
REQ-007 tens  input  4  current BCD tens digit from the occupancy counter.
REQ-008 cnt_en  output  1  one-cycle count-enable pulse to the occupancy counter.
REQ-009 cnt_up  output  1  count direction to the counter, 1 = increment; valid while cnt_en = 1.
REQ-010 full  output  1  combinational, 1 when tens = 9 and units = 9.
REQ-011 empty  output  1  combinational, 1 when tens = 0 and units = 0.
REQ-012 reject  output  1  one-cycle pulse: valid car event suppressed by full/empty.
REQ-013 seq_err  output  1  one-cycle pulse: illegal sensor transition detected.

Function
REQ-014 sens_a/sens_b SHALL each pass through SYNC_STAGES flops; the FSM SHALL use only synchronized values {a,b}.
REQ-015 FSM states: IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_AB, OUT_A, ERR.
REQ-016 Entry path: IDLE-(10)->IN_A-(11)->IN_AB-(01)->IN_B-(00)->IDLE, final transition producing a car_in event.
REQ-017 Exit path: IDLE-(01)->OUT_B-(11)->OUT_AB-(10)->OUT_A-(00)->IDLE, final transition producing a car_out event.
REQ-018 Backing off: each path state SHALL return to its predecessor on that predecessor's {a,b} code (e.g. IN_AB-(10)->IN_A, IN_A-(00)->IDLE) without any event.
REQ-019 Unchanged {a,b} SHALL hold the current state.
REQ-020 Any other code (two-bit change, e.g. IDLE-(11), IN_A-(01)) SHALL go to ERR and pulse seq_err for one cycle; ERR SHALL hold until {a,b}=00, then go to IDLE with no event.
REQ-021 car_in with full=0: cnt_en=1, cnt_up=1 for one cycle; car_in with full=1: cnt_en=0, reject=1 for one cycle.
REQ-022 car_out with empty=0: cnt_en=1, cnt_up=0 for one cycle; car_out with empty=1: cnt_en=0, reject=1 for one cycle.
REQ-023 cnt_en, cnt_up, reject, seq_err SHALL be registered; cnt_en/reject asserted on the same edge the FSM enters IDLE from IN_B/OUT_A.
REQ-024 Latency (SYNC_STAGES=2): the completing raw 00 first sampled at edge N SHALL yield cnt_en high from edge N+2 to N+3.
REQ-025 full/empty SHALL be evaluated from units/tens in the cycle the FSM completes the sequence; the counter never wraps 99->00 or 00->99 via this block.
REQ-026 cnt_up SHALL hold its last value when cnt_en=0; it SHALL never change in the same cycle cnt_en is high except as set by the event.
REQ-027 At most one of cnt_en, reject, seq_err SHALL be high in any cycle.

Reset
REQ-028 rst=1 at an edge: FSM to IDLE, all synchronizer flops to 0, cnt_en=0, cnt_up=1, reject=0, seq_err=0.
REQ-029 rst mid-sequence SHALL abort the sequence with no event; after release, a fresh sequence from IDLE is required.

Structure
REQ-030 State enum typedef and BCD max constants (MAX_UNITS=9, MAX_TENS=9) SHALL live in shared package car_pkg.
REQ-031 Synchronizer SHALL be a sub-module bit_sync (parameter STAGES), instantiated once per sensor.
REQ-032 Block SHALL not instantiate the counter; it drives the counter's en/up ports externally.

Verification
REQ-033 Count 05; raw sequence 00,10,11,01,00 (each held 4 cycles) -> single cnt_en pulse, cnt_up=1, 2 edges after final 00; counter reads 06.
REQ-034 Count 05; sequence 00,01,11,10,00 -> single cnt_en pulse, cnt_up=0; counter reads 04.
REQ-035 Count 99 entry sequence -> cnt_en stays 0, reject one cycle, count stays 99; count 00 exit sequence -> reject, count stays 00.
REQ-036 Sequence 00,10,11,10,00 (back-off) -> no cnt_en, reject or seq_err.
REQ-037 Raw 00->11 directly -> seq_err one cycle, state ERR; then 01 -> still ERR; 00 -> IDLE, no cnt_en.
REQ-038 rst pulsed while in IN_AB, then 01,00 -> no event; outputs at reset values; next full entry sequence counts normally.

Source files
------------

// File: rtl/car_pkg.sv
// Shared types and constants for the car park entry/exit flow controller.
// Holds the FSM state encoding, the BCD limits and the sensor transition table.
package car_pkg;

  typedef enum logic [2:0] {
    IDLE,
    IN_A,
    IN_AB,
    IN_B,
    OUT_B,
    OUT_AB,
    OUT_A,
    ERR
  } state_t;

  localparam logic [3:0] MAX_UNITS = 4'd9;
  localparam logic [3:0] MAX_TENS  = 4'd9;

  // {a,b} codes: 10 = only outer blocked, 01 = only inner blocked.
  // Path states move forward, back off to their predecessor, or hold.
  // Every other code is a two-bit jump and lands in ERR.
  function automatic state_t next_state(input state_t s, input logic [1:0] ab);
    next_state = ERR;
    case (s)
      IDLE: case (ab)
        2'b00:   next_state = IDLE;
        2'b10:   next_state = IN_A;
        2'b01:   next_state = OUT_B;
        default: next_state = ERR;
      endcase
      IN_A: case (ab)
        2'b10:   next_state = IN_A;
        2'b11:   next_state = IN_AB;
        2'b00:   next_state = IDLE;
        default: next_state = ERR;
      endcase
      IN_AB: case (ab)
        2'b11:   next_state = IN_AB;
        2'b01:   next_state = IN_B;
        2'b10:   next_state = IN_A;
        default: next_state = ERR;
      endcase
      IN_B: case (ab)
        2'b01:   next_state = IN_B;
        2'b00:   next_state = IDLE;
        2'b11:   next_state = IN_AB;
        default: next_state = ERR;
      endcase
      OUT_B: case (ab)
        2'b01:   next_state = OUT_B;
        2'b11:   next_state = OUT_AB;
        2'b00:   next_state = IDLE;
        default: next_state = ERR;
      endcase
      OUT_AB: case (ab)
        2'b11:   next_state = OUT_AB;
        2'b10:   next_state = OUT_A;
        2'b01:   next_state = OUT_B;
        default: next_state = ERR;
      endcase
      OUT_A: case (ab)
        2'b10:   next_state = OUT_A;
        2'b00:   next_state = IDLE;
        2'b11:   next_state = OUT_AB;
        default: next_state = ERR;
      endcase
      ERR:     next_state = (ab == 2'b00) ? IDLE : ERR;
      default: next_state = ERR;
    endcase
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer bringing one asynchronous bit into the clk domain.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], d};
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/car_flow_ctrl.sv
// Two-beam car direction detector driving an external BCD occupancy counter.
// Emits one count pulse per completed pass, or a reject when the count is at its limit.
module car_flow_ctrl
  import car_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sens_a,
  input  logic       sens_b,
  input  logic [3:0] units,
  input  logic [3:0] tens,
  output logic       cnt_en,
  output logic       cnt_up,
  output logic       full,
  output logic       empty,
  output logic       reject,
  output logic       seq_err
);

  logic   a_sync;
  logic   b_sync;
  logic   [1:0] ab;
  state_t state_reg;
  state_t state_next;
  logic   car_in;
  logic   car_out;
  logic   to_err;

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync_a (.clk(clk), .rst(rst), .d(sens_a), .q(a_sync));
  bit_sync #(.STAGES(SYNC_STAGES)) u_sync_b (.clk(clk), .rst(rst), .d(sens_b), .q(b_sync));

  assign ab    = {a_sync, b_sync};
  assign full  = (tens == MAX_TENS) && (units == MAX_UNITS);
  assign empty = (tens == 4'd0) && (units == 4'd0);

  always_comb begin
    state_next = next_state(state_reg, ab);
    car_in     = (state_reg == IN_B)  && (ab == 2'b00);
    car_out    = (state_reg == OUT_A) && (ab == 2'b00);
    to_err     = (state_next == ERR)  && (state_reg != ERR);
  end

  // Outputs are registered so they change on the same edge the FSM returns to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_en    <= 1'b0;
      cnt_up    <= 1'b1;
      reject    <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_en    <= 1'b0;
      reject    <= 1'b0;
      seq_err   <= to_err;
      if (car_in) begin
        if (full) begin
          reject <= 1'b1;
        end else begin
          cnt_en <= 1'b1;
          cnt_up <= 1'b1;
        end
      end else if (car_out) begin
        if (empty) begin
          reject <= 1'b1;
        end else begin
          cnt_en <= 1'b1;
          cnt_up <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_car_flow_ctrl.sv
// Directed bench for car_flow_ctrl with a behavioural occupancy counter in the loop.
module tb_car_flow_ctrl;
  import car_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sens_a = 1'b0;
  logic       sens_b = 1'b0;
  logic [3:0] units;
  logic [3:0] tens;
  logic       cnt_en;
  logic       cnt_up;
  logic       full;
  logic       empty;
  logic       reject;
  logic       seq_err;

  int checks = 0;
  int fails  = 0;

  // Counter model and pulse tallies, written only by the monitor process.
  logic load = 1'b0;
  int   load_val = 0;
  int   count = 0;
  int   en_cnt = 0;
  int   rej_cnt = 0;
  int   err_cnt = 0;
  int   excl_viol = 0;
  int   en_base, rej_base, err_base;

  car_flow_ctrl #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sens_a(sens_a), .sens_b(sens_b),
    .units(units), .tens(tens), .cnt_en(cnt_en), .cnt_up(cnt_up),
    .full(full), .empty(empty), .reject(reject), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  assign units = 4'(count % 10);
  assign tens  = 4'(count / 10);

  always @(posedge clk) begin
    if (load) count <= load_val;
    else if (cnt_en) count <= cnt_up ? count + 1 : count - 1;
    if (cnt_en)  en_cnt  <= en_cnt + 1;
    if (reject)  rej_cnt <= rej_cnt + 1;
    if (seq_err) err_cnt <= err_cnt + 1;
    if (32'(cnt_en) + 32'(reject) + 32'(seq_err) > 1) excl_viol <= excl_viol + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [1:0] ab, input int n);
    sens_a = ab[1];
    sens_b = ab[0];
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_count(input int v);
    load_val = v;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic snap();
    en_base  = en_cnt;
    rej_base = rej_cnt;
    err_base = err_cnt;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    set_count(5);
    check("rst_cnt_en",  int'(cnt_en),  0);
    check("rst_cnt_up",  int'(cnt_up),  1);
    check("rst_reject",  int'(reject),  0);
    check("rst_seq_err", int'(seq_err), 0);
    check("rst_state",   int'(dut.state_reg), int'(IDLE));
    check("full_at_05",  int'(full),  0);
    check("empty_at_05", int'(empty), 0);

    // Entry at 05 with exact latency of the count pulse.
    snap();
    hold(2'b00, 4); hold(2'b10, 4); hold(2'b11, 4); hold(2'b01, 4);
    sens_a = 1'b0; sens_b = 1'b0;
    @(posedge clk); #1; check("in_lat_n",   int'(cnt_en), 0);
    @(posedge clk); #1; check("in_lat_n1",  int'(cnt_en), 0);
    @(posedge clk); #1; check("in_lat_n2",  int'(cnt_en), 1);
    check("in_up", int'(cnt_up), 1);
    @(posedge clk); #1; check("in_lat_n3",  int'(cnt_en), 0);
    hold(2'b00, 4);
    check("in_pulses", en_cnt - en_base, 1);
    check("in_count",  count, 6);

    // Exit at 05.
    set_count(5);
    snap();
    hold(2'b01, 4); hold(2'b11, 4); hold(2'b10, 4); hold(2'b00, 6);
    check("out_pulses", en_cnt - en_base, 1);
    check("out_up_held", int'(cnt_up), 0);
    check("out_count", count, 4);

    // Entry when full, exit when empty.
    set_count(99);
    check("full_at_99", int'(full), 1);
    snap();
    hold(2'b10, 4); hold(2'b11, 4); hold(2'b01, 4); hold(2'b00, 6);
    check("full_en",  en_cnt - en_base, 0);
    check("full_rej", rej_cnt - rej_base, 1);
    check("full_count", count, 99);
    set_count(0);
    check("empty_at_00", int'(empty), 1);
    snap();
    hold(2'b01, 4); hold(2'b11, 4); hold(2'b10, 4); hold(2'b00, 6);
    check("empty_en",  en_cnt - en_base, 0);
    check("empty_rej", rej_cnt - rej_base, 1);
    check("empty_count", count, 0);

    // Back-off mid entry.
    set_count(20);
    snap();
    hold(2'b10, 4); hold(2'b11, 4); hold(2'b10, 4); hold(2'b00, 6);
    check("back_en",  en_cnt - en_base, 0);
    check("back_rej", rej_cnt - rej_base, 0);
    check("back_err", err_cnt - err_base, 0);
    check("back_state", int'(dut.state_reg), int'(IDLE));

    // Illegal two-bit jump.
    snap();
    hold(2'b11, 5);
    check("err_pulse", err_cnt - err_base, 1);
    check("err_state", int'(dut.state_reg), int'(ERR));
    hold(2'b01, 4);
    check("err_hold", int'(dut.state_reg), int'(ERR));
    check("err_no_more", err_cnt - err_base, 1);
    hold(2'b00, 4);
    check("err_exit", int'(dut.state_reg), int'(IDLE));
    check("err_no_en", en_cnt - en_base, 0);

    // Reset while in IN_AB aborts the pass.
    set_count(10);
    hold(2'b10, 4); hold(2'b11, 4);
    check("abort_in_ab", int'(dut.state_reg), int'(IN_AB));
    snap();
    rst = 1'b1; sens_a = 1'b0; sens_b = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_cnt_up", int'(cnt_up), 1);
    check("abort_state",  int'(dut.state_reg), int'(IDLE));
    hold(2'b01, 4); hold(2'b00, 6);
    check("abort_en",  en_cnt - en_base, 0);
    check("abort_rej", rej_cnt - rej_base, 0);
    check("abort_err", err_cnt - err_base, 0);
    hold(2'b10, 4); hold(2'b11, 4); hold(2'b01, 4); hold(2'b00, 6);
    check("after_abort_en", en_cnt - en_base, 1);
    check("after_abort_count", count, 11);

    check("exclusive_outputs", excl_viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
